// File: rtl/cipher_frame_tx_if.sv
// cipher_frame_tx_if: bundles the framer's capture inputs, UART handshake and status outputs.
// Ports: start_i/cipher_i/tag_i from the cipher side, tx_busy_i from the UART,
//        tx_byte_o/load_o toward the UART, busy_o/done_o status.
interface cipher_frame_tx_if #(
  parameter int NDBits      = 8,
  parameter int NWAVE_BYTES = 184,
  parameter int NTAG_BYTES  = 16
);
  logic                     start_i;
  logic [NWAVE_BYTES*8-1:0] cipher_i;
  logic [NTAG_BYTES*8-1:0]  tag_i;
  logic                     tx_busy_i;
  logic [NDBits-1:0]        tx_byte_o;
  logic                     load_o;
  logic                     busy_o;
  logic                     done_o;

  // framer side
  modport slave (
    input  start_i, cipher_i, tag_i, tx_busy_i,
    output tx_byte_o, load_o, busy_o, done_o
  );

  // stimulus / upstream + UART side
  modport master (
    output start_i, cipher_i, tag_i, tx_busy_i,
    input  tx_byte_o, load_o, busy_o, done_o
  );
endinterface

// File: rtl/cipher_frame_tx.sv
// cipher_frame_tx: frames a captured cipher wave + ASCON tag as HEADER, data bytes, tag bytes, TRAILER.
// Latency: first load_o one cycle after start_i (if the UART is idle); one byte per UART load/busy round trip.
// Backpressure: waits in LOAD while tx_busy_i is high; a busy edge that never comes times out after BUSY_TIMEOUT.
// Ports: clock_i, resetb_i (async, active low); bus (slave): start_i, cipher_i, tag_i, tx_busy_i in;
//        tx_byte_o, load_o, busy_o, done_o out.
module cipher_frame_tx #(
  parameter int                NDBits       = 8,
  parameter int                NWAVE_BYTES  = 184,
  parameter int                NTAG_BYTES   = 16,
  parameter logic [NDBits-1:0] HEADER       = 8'h43,
  parameter logic [NDBits-1:0] TRAILER      = 8'h0A,
  parameter int                BUSY_TIMEOUT = 15
) (
  input logic               clock_i,
  input logic               resetb_i,
  cipher_frame_tx_if.slave  bus
);

  localparam int             NBYTES   = NWAVE_BYTES + NTAG_BYTES;
  localparam int             SHW      = NBYTES * 8;
  localparam logic [7:0]     LAST_IDX = 8'(NBYTES + 1);
  localparam logic [3:0]     TMO      = 4'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [SHW-1:0]    shadow;
  logic [7:0]        idx;
  logic [3:0]        tmo_cnt;
  logic [NDBits-1:0] byte_q;
  logic [NDBits-1:0] cur_byte;
  logic              load;
  logic              capture;
  logic              advance;

  // Byte for the current index: framing bytes at both ends, otherwise the
  // top of the shadow register (already shifted to the right byte).
  always_comb begin
    cur_byte = shadow[SHW-1 -: NDBits];
    if (idx == 8'd0) begin
      cur_byte = HEADER;
    end else if (idx == LAST_IDX) begin
      cur_byte = TRAILER;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          capture   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // load is combinational so the byte goes out in the first idle cycle
        if (!bus.tx_busy_i) begin
          load      = 1'b1;
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy_i) begin
          state_nxt = S_WAIT_IDLE;
        end else if (tmo_cnt == TMO) begin
          // UART never acknowledged; assume the byte was taken
          state_nxt = S_NEXT;
        end
      end
      S_WAIT_IDLE: begin
        if (!bus.tx_busy_i) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Index and shadow register: the shift happens only after a data byte
  // (index 1..200); the header slot leaves the shadow untouched.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      idx    <= 8'd0;
      shadow <= '0;
    end else if (capture) begin
      idx    <= 8'd0;
      shadow <= {bus.cipher_i, bus.tag_i};
    end else if (advance) begin
      idx <= idx + 8'd1;
      if (idx != 8'd0) begin
        shadow <= {shadow[SHW-NDBits-1:0], {NDBits{1'b0}}};
      end
    end
  end

  // Saturating wait counter for the busy acknowledge.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      tmo_cnt <= 4'd0;
    end else if (load) begin
      tmo_cnt <= 4'd0;
    end else if (state == S_WAIT_BUSY && tmo_cnt != TMO) begin
      tmo_cnt <= tmo_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      byte_q <= '0;
    end else if (load) begin
      byte_q <= cur_byte;
    end
  end

  assign bus.load_o    = load;
  assign bus.tx_byte_o = load ? cur_byte : byte_q;
  assign bus.busy_o    = (state != S_IDLE);
  assign bus.done_o    = (state == S_DONE);

endmodule

// File: tb/tb_cipher_frame_tx.sv
// tb_cipher_frame_tx: directed frames against a byte-list model of the framer output.
// Ports: none; drives cipher_frame_tx through its interface with a simple UART busy model.
module tb_cipher_frame_tx;

  localparam int NFRAME = 202;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  cipher_frame_tx_if bus ();

  cipher_frame_tx dut (
    .clock_i  (clk),
    .resetb_i (resetb),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [7:0] exp_b  [NFRAME];
  logic [7:0] loaded [NFRAME];
  int frame_gen = 0;
  int pos = 0;
  int done_cnt = 0;
  int cyc = 0;
  int uart_mode = 0;     // 0: busy 20 cycles, rising 2 cycles after load; 1: never busy
  logic uart_busy = 1'b0;
  logic force_busy = 1'b0;

  assign bus.tx_busy_i = uart_busy | force_busy;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Expected frame straight from the layout rule: header, cipher MSB-first, tag MSB-first, trailer.
  task automatic set_model(input logic [1471:0] c, input logic [127:0] t);
    exp_b[0] = 8'h43;
    for (int i = 0; i < 184; i++) exp_b[1 + i] = c[1471 - 8*i -: 8];
    for (int i = 0; i < 16; i++)  exp_b[185 + i] = t[127 - 8*i -: 8];
    exp_b[201] = 8'h0A;
    frame_gen++;
  endtask

  task automatic pulse_start(input logic [1471:0] c, input logic [127:0] t);
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.cipher_i = c;
    bus.tag_i    = t;
    @(posedge clk); #1;
    bus.start_i  = 1'b0;
  endtask

  task automatic run_to_done(input string nm, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    check({nm, " done pulse"}, 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    check({nm, " busy after done"}, 32'(bus.busy_o), 32'd0);
    check({nm, " byte count"}, 32'(pos), 32'(NFRAME));
    repeat (30) @(posedge clk);
    check({nm, " single done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_pos(input string nm, input int target);
    for (int i = 0; i < 6000 && pos < target; i++) @(posedge clk);
    check({nm, " reached byte"}, 32'(pos >= target), 32'd1);
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART model
  initial forever begin
    @(negedge clk);
    if (uart_mode == 0 && resetb && bus.load_o) begin
      @(posedge clk);
      @(posedge clk); #1;
      uart_busy = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      uart_busy = 1'b0;
    end
  end

  // compare process: every load and done checked against the model
  initial begin
    int seen_gen;
    int last_load;
    int gap;
    seen_gen  = 0;
    last_load = -1;
    forever begin
      @(negedge clk);
      if (frame_gen != seen_gen) begin
        seen_gen  = frame_gen;
        pos       = 0;
        last_load = -1;
      end
      if (resetb) begin
        if (bus.load_o) begin
          check("load while tx_busy", 32'(bus.tx_busy_i), 32'd0);
          if (pos < NFRAME) begin
            check($sformatf("frame byte %0d", pos), 32'(bus.tx_byte_o), 32'(exp_b[pos]));
            loaded[pos] = bus.tx_byte_o;
          end else begin
            check("load beyond frame end", 32'(pos), 32'(NFRAME - 1));
          end
          gap = cyc - last_load;
          if (last_load >= 0 && uart_mode == 0)
            check("load gap", 32'(gap), 32'd24);
          if (last_load >= 0 && uart_mode == 1)
            check("timeout gap in range", 32'(gap >= 16 && gap <= 19), 32'd1);
          last_load = cyc;
          pos++;
        end
        if (bus.done_o) begin
          check("done after last byte", 32'(pos), 32'(NFRAME));
          if (uart_mode == 0)
            check("done latency", 32'(cyc - last_load), 32'd24);
          done_cnt++;
        end
      end
    end
  end

  initial begin
    logic [1471:0] c_nom, c_alt, c_ones;
    logic [127:0]  t_nom, t_alt, t_ones;
    for (int i = 0; i < 184; i++) begin
      c_nom[1471 - 8*i -: 8] = 8'(i);
      c_alt[1471 - 8*i -: 8] = 8'(i * 7 + 3);
    end
    for (int i = 0; i < 16; i++) begin
      t_nom[127 - 8*i -: 8] = 8'(8'hF0 + i);
      t_alt[127 - 8*i -: 8] = 8'(8'h55 ^ i);
    end
    c_ones = '1;
    t_ones = '1;

    bus.start_i  = 1'b0;
    bus.cipher_i = '0;
    bus.tag_i    = '0;

    // reset values
    @(negedge clk);
    check("reset tx_byte", 32'(bus.tx_byte_o), 32'd0);
    check("reset load", 32'(bus.load_o), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    check("reset done", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1;
    resetb = 1'b1;
    repeat (3) @(posedge clk);

    // nominal frame; header appears one cycle after start
    set_model(c_nom, t_nom);
    pulse_start(c_nom, t_nom);
    @(negedge clk);
    check("start busy_o", 32'(bus.busy_o), 32'd1);
    check("start load_o", 32'(bus.load_o), 32'd1);
    check("start header", 32'(bus.tx_byte_o), 32'h43);
    run_to_done("nominal", 6000);
    check("nominal byte 1", 32'(loaded[1]), 32'h00);
    check("nominal byte 184", 32'(loaded[184]), 32'hB7);
    check("nominal byte 185", 32'(loaded[185]), 32'hF0);
    check("nominal byte 200", 32'(loaded[200]), 32'hFF);
    check("nominal byte 201", 32'(loaded[201]), 32'h0A);
    check("hold last byte", 32'(bus.tx_byte_o), 32'h0A);

    // capture isolation: inputs go all-ones the cycle after start
    set_model(c_alt, t_alt);
    pulse_start(c_alt, t_alt);
    bus.cipher_i = c_ones;
    bus.tag_i    = t_ones;
    run_to_done("isolation", 6000);
    check("isolation byte 2", 32'(loaded[2]), 32'h0A);

    // busy held across start: no load until it drops
    force_busy = 1'b1;
    repeat (20) @(posedge clk);
    set_model(c_nom, t_nom);
    pulse_start(c_nom, t_nom);
    @(negedge clk);
    check("busy-start busy_o", 32'(bus.busy_o), 32'd1);
    check("busy-start no load", 32'(bus.load_o), 32'd0);
    repeat (28) @(posedge clk);
    check("busy-start loads held", 32'(pos), 32'd0);
    #1;
    force_busy = 1'b0;
    @(negedge clk);
    check("busy-start load", 32'(bus.load_o), 32'd1);
    check("busy-start header", 32'(bus.tx_byte_o), 32'h43);
    run_to_done("busy-start", 6000);

    // UART never acknowledges
    uart_mode = 1;
    set_model(c_alt, t_nom);
    pulse_start(c_alt, t_nom);
    run_to_done("timeout", 5000);
    uart_mode = 0;

    // stray start mid-frame is ignored
    set_model(c_nom, t_alt);
    pulse_start(c_nom, t_alt);
    wait_pos("stray", 50);
    pulse_start(c_ones, t_ones);
    run_to_done("stray", 6000);

    // reset mid-frame, then a fresh full frame
    set_model(c_alt, t_alt);
    pulse_start(c_alt, t_alt);
    wait_pos("reset", 100);
    @(posedge clk); #1;
    resetb = 1'b0;
    #1;
    check("mid reset tx_byte", 32'(bus.tx_byte_o), 32'd0);
    check("mid reset load", 32'(bus.load_o), 32'd0);
    check("mid reset busy", 32'(bus.busy_o), 32'd0);
    check("mid reset done", 32'(bus.done_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetb = 1'b1;
    repeat (30) @(posedge clk);
    set_model(c_nom, t_nom);
    pulse_start(c_nom, t_nom);
    run_to_done("after reset", 6000);
    check("after reset header", 32'(loaded[0]), 32'h43);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
